// File: rtl/soft_frame_assembler.sv
// Soft-sample front end for the (8,4) decoder: rescales and saturates serial samples,
// then packs groups of eight into a parallel frame behind a valid/ready handshake.
module soft_frame_assembler #(
    parameter int IN_W       = 8,
    parameter int FRAC_SHIFT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_sample,
    input  logic            in_sof,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      r_out [0:7],
    output logic [7:0]      sat_count,
    output logic            sync_err
);

    logic [3:0] cnt_q, cnt_d;
    logic [5:0] smp_buf_q [0:7];
    logic [5:0] smp_buf_d [0:7];
    logic [5:0] r_out_q [0:7];
    logic [5:0] r_out_d [0:7];
    logic       out_valid_q, out_valid_d;
    logic [7:0] sat_count_q, sat_count_d;
    logic       sync_err_q, sync_err_d;

    logic signed [IN_W-1:0] q_s;
    logic [IN_W-6:0]        q_upper;
    logic                   q_fits;
    logic                   clip;
    logic [5:0]             q_val;
    logic                   accept;
    logic                   transfer;

    // The shifted value fits in 6-bit signed when every bit above bit 4 matches the sign.
    always_comb begin
        q_s     = $signed(in_sample) >>> FRAC_SHIFT;
        q_upper = q_s[IN_W-1:5];
        q_fits  = (&q_upper) | (~|q_upper);
        clip    = !q_fits;
        if (q_fits) begin
            q_val = q_s[5:0];
        end else if (q_s[IN_W-1]) begin
            q_val = 6'b100000;
        end else begin
            q_val = 6'b011111;
        end
    end

    assign in_ready = (cnt_q < 4'd8);
    assign accept   = in_valid && in_ready;
    assign transfer = (cnt_q == 4'd8) && (!out_valid_q || out_ready);

    always_comb begin
        cnt_d       = cnt_q;
        smp_buf_d   = smp_buf_q;
        r_out_d     = r_out_q;
        out_valid_d = out_valid_q;
        sat_count_d = sat_count_q;
        sync_err_d  = 1'b0;

        // Accept and transfer are exclusive: accept needs cnt<8, transfer needs cnt==8.
        if (transfer) begin
            r_out_d     = smp_buf_q;
            out_valid_d = 1'b1;
            cnt_d       = 4'd0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_sof) begin
                smp_buf_d[0] = q_val;
                cnt_d        = 4'd1;
                sync_err_d   = (cnt_q != 4'd0);
            end else begin
                smp_buf_d[cnt_q[2:0]] = q_val;
                cnt_d                 = cnt_q + 4'd1;
            end
            if (clip && (sat_count_q != 8'hFF)) begin
                sat_count_d = sat_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            sat_count_q <= 8'd0;
            sync_err_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                smp_buf_q[i] <= 6'd0;
                r_out_q[i]   <= 6'd0;
            end
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sat_count_q <= sat_count_d;
            sync_err_q  <= sync_err_d;
            smp_buf_q   <= smp_buf_d;
            r_out_q     <= r_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sat_count = sat_count_q;
    assign sync_err  = sync_err_q;
    assign r_out     = r_out_q;

endmodule

// File: tb/tb_soft_frame_assembler.sv
// Directed bench for soft_frame_assembler: reset, quantization, backpressure,
// resync, saturation counter and mid-operation reset.
module tb_soft_frame_assembler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_sample = 8'd0;
    logic       in_sof = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] r_out [0:7];
    logic [7:0] sat_count;
    logic       sync_err;

    int checks = 0;
    int failures = 0;

    soft_frame_assembler #(.IN_W(8), .FRAC_SHIFT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .sat_count (sat_count),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] frame6(input int v0, input int v1, input int v2, input int v3,
                                           input int v4, input int v5, input int v6, input int v7);
        return {6'(v0), 6'(v1), 6'(v2), 6'(v3), 6'(v4), 6'(v5), 6'(v6), 6'(v7)};
    endfunction

    function automatic logic [47:0] r_packed();
        return {r_out[0], r_out[1], r_out[2], r_out[3], r_out[4], r_out[5], r_out[6], r_out[7]};
    endfunction

    // Present one sample, wait (bounded) for in_ready, and let it be accepted on the next edge.
    task automatic send(input logic sof, input int value);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_sof    = sof;
        in_sample = 8'(value);
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        // Reset asserted mid-cycle, checked before any clock edge
        #3;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_r_out", r_packed(), 48'd0);
        chk("rst_sat_count", sat_count, 8'd0);
        chk("rst_sync_err", sync_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        step();
        reset = 1'b0;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Basic frame with clipping
        out_ready = 1'b1;
        send(1'b1, 0);
        chk("basic_sof_no_err", sync_err, 1'b0);
        send(1'b0, 2);
        send(1'b0, -3);
        send(1'b0, 100);
        send(1'b0, -100);
        send(1'b0, 63);
        send(1'b0, -64);
        send(1'b0, 7);
        chk("basic_stall_in_ready", in_ready, 1'b0);
        chk("basic_not_yet_valid", out_valid, 1'b0);
        step();
        chk("basic_out_valid", out_valid, 1'b1);
        chk("basic_frame", r_packed(), frame6(0, 1, -2, 31, -32, 31, -32, 3));
        chk("basic_sat_count", sat_count, 8'd2);
        step();
        chk("basic_one_cycle", out_valid, 1'b0);

        // Backpressure: frame A held while frame B fills behind it
        out_ready = 1'b0;
        send(1'b1, 2);
        for (int i = 2; i <= 8; i++) send(1'b0, 2 * i);
        send(1'b1, -2);
        for (int i = 2; i <= 8; i++) send(1'b0, -2 * i);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid_a", out_valid, 1'b1);
        chk("bp_hold_a", r_packed(), frame6(1, 2, 3, 4, 5, 6, 7, 8));
        step();
        step();
        chk("bp_still_hold_a", r_packed(), frame6(1, 2, 3, 4, 5, 6, 7, 8));
        chk("bp_still_blocked", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_frame_b", r_packed(), frame6(-1, -2, -3, -4, -5, -6, -7, -8));
        chk("bp_valid_no_bubble", out_valid, 1'b1);
        chk("bp_in_ready_back", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        chk("bp_drained", out_valid, 1'b0);

        // Resync: partial frame of 3 dropped by in_sof
        send(1'b1, 2);
        send(1'b0, 4);
        send(1'b0, 6);
        chk("resync_err_quiet", sync_err, 1'b0);
        send(1'b1, 10);
        chk("resync_err_pulse", sync_err, 1'b1);
        send(1'b0, 12);
        chk("resync_err_one_cycle", sync_err, 1'b0);
        for (int i = 7; i <= 12; i++) send(1'b0, 2 * i);
        step();
        chk("resync_out_valid", out_valid, 1'b1);
        chk("resync_frame", r_packed(), frame6(5, 6, 7, 8, 9, 10, 11, 12));
        chk("resync_sat_unchanged", sat_count, 8'd2);

        // Saturation counter: 300 clipped samples on top of the 2 earlier ones
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 127);
            if (i == 251) chk("sat_254", sat_count, 8'd254);
            if (i == 252) chk("sat_255", sat_count, 8'd255);
        end
        chk("sat_hold_255", sat_count, 8'd255);
        chk("sat_frame_all31", r_packed(), frame6(31, 31, 31, 31, 31, 31, 31, 31));

        // Reset mid-operation: 4 leftovers complete a held frame, then 5 more in progress
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 127);
        send(1'b1, 40);
        for (int i = 0; i < 4; i++) send(1'b0, 40);
        chk("mid_held_valid", out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_r_out", r_packed(), 48'd0);
        chk("mid_rst_sat", sat_count, 8'd0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b0, 20 + 2 * i);
        step();
        chk("mid_fresh_valid", out_valid, 1'b1);
        chk("mid_fresh_frame", r_packed(), frame6(10, 11, 12, 13, 14, 15, 16, 17));
        chk("mid_fresh_no_err", sync_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
